// File: rtl/quad_texel_interp.sv
// Point-in-quad test over triangles (v0,v1,v2) and (v0,v2,v3) with barycentric
// interpolation of u, v and z, using three bit-serial restoring dividers.
module quad_texel_interp #(
   parameter int COORD_W = 10,
   parameter int UV_W = 4,
   parameter int Z_W = 16,
   parameter logic [Z_W-1:0] Z_FAR = {Z_W{1'b1}}
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [COORD_W-1:0] x0, x1, x2, x3,
   input  logic signed [COORD_W-1:0] y0, y1, y2, y3,
   input  logic [UV_W-1:0]           u0, u1, u2, u3,
   input  logic [UV_W-1:0]           v0, v1, v2, v3,
   input  logic signed [Z_W-1:0]     z0, z1, z2, z3,
   input  logic signed [COORD_W-1:0] qx, qy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      is_inside,
   output logic                      tri_id,
   output logic [UV_W-1:0]           qu, qv,
   output logic [Z_W-1:0]            qz
);

   localparam int AREA_W = 2*COORD_W+3;
   localparam int NUM_W  = Z_W+AREA_W+2;
   localparam int D_W    = AREA_W+2;
   localparam int CNT_W  = $clog2(NUM_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_W-1);
   localparam logic [NUM_W-1:0] UV_MAX = {{(NUM_W-UV_W){1'b0}}, {UV_W{1'b1}}};
   localparam logic [NUM_W-1:0] Z_MAX  = {{(NUM_W-Z_W+1){1'b0}}, {(Z_W-1){1'b1}}};
   localparam logic signed [AREA_W-1:0] A_ZERO = {AREA_W{1'b0}};

   typedef enum logic [1:0] {IDLE = 2'd0, AREA = 2'd1, DIVIDE = 2'd2, HOLD = 2'd3} state_t;

   function automatic logic signed [AREA_W-1:0] ext_c(input logic signed [COORD_W-1:0] c);
      ext_c = $signed({{(AREA_W-COORD_W){c[COORD_W-1]}}, c});
   endfunction

   function automatic logic signed [AREA_W-1:0] area_f(
      input logic signed [COORD_W-1:0] px, py, ax, ay, bx, by);
      area_f = (ext_c(px) - ext_c(ax)) * (ext_c(by) - ext_c(ay))
             - (ext_c(py) - ext_c(ay)) * (ext_c(bx) - ext_c(ax));
   endfunction

   function automatic logic signed [D_W-1:0] sum3_d(input logic signed [AREA_W-1:0] a, b, c);
      sum3_d = $signed({{(D_W-AREA_W){a[AREA_W-1]}}, a})
             + $signed({{(D_W-AREA_W){b[AREA_W-1]}}, b})
             + $signed({{(D_W-AREA_W){c[AREA_W-1]}}, c});
   endfunction

   // Edges are inclusive; a zero-area triangle never hits.
   function automatic logic inside_f(input logic signed [AREA_W-1:0] a, b, c);
      logic all_nonneg;
      logic all_nonpos;
      all_nonneg = !a[AREA_W-1] && !b[AREA_W-1] && !c[AREA_W-1];
      all_nonpos = (a[AREA_W-1] || (a == A_ZERO)) && (b[AREA_W-1] || (b == A_ZERO))
                && (c[AREA_W-1] || (c == A_ZERO));
      inside_f = (all_nonneg || all_nonpos) && (sum3_d(a, b, c) != {D_W{1'b0}});
   endfunction

   function automatic logic signed [NUM_W-1:0] ext_a(input logic signed [AREA_W-1:0] a);
      ext_a = $signed({{(NUM_W-AREA_W){a[AREA_W-1]}}, a});
   endfunction

   function automatic logic signed [NUM_W-1:0] ext_uv(input logic [UV_W-1:0] t);
      ext_uv = $signed({{(NUM_W-UV_W){1'b0}}, t});
   endfunction

   function automatic logic signed [NUM_W-1:0] ext_z(input logic signed [Z_W-1:0] z);
      ext_z = $signed({{(NUM_W-Z_W){z[Z_W-1]}}, z});
   endfunction

   function automatic logic signed [NUM_W-1:0] dot3(
      input logic signed [NUM_W-1:0] c0, c1, c2, w0, w1, w2);
      dot3 = c0 * w0 + c1 * w1 + c2 * w2;
   endfunction

   function automatic logic [NUM_W-1:0] mag_n(input logic signed [NUM_W-1:0] n);
      mag_n = n[NUM_W-1] ? -n : n;
   endfunction

   function automatic logic [D_W-1:0] mag_d(input logic signed [D_W-1:0] d);
      mag_d = d[D_W-1] ? -d : d;
   endfunction

   // One restoring step: shift the next numerator bit into the remainder, quotient bit into the LSB.
   function automatic logic [D_W+NUM_W-1:0] div_step(
      input logic [D_W-1:0] rem, input logic [NUM_W-1:0] nq, input logic [D_W-1:0] d);
      logic [D_W:0] shifted;
      shifted = {rem, nq[NUM_W-1]};
      if (shifted >= {1'b0, d})
         div_step = {D_W'(shifted - {1'b0, d}), nq[NUM_W-2:0], 1'b1};
      else
         div_step = {shifted[D_W-1:0], nq[NUM_W-2:0], 1'b0};
   endfunction

   function automatic logic [UV_W-1:0] sat_uv(input logic neg, input logic [NUM_W-1:0] q);
      if (neg)
         sat_uv = {UV_W{1'b0}};
      else if (q > UV_MAX)
         sat_uv = {UV_W{1'b1}};
      else
         sat_uv = q[UV_W-1:0];
   endfunction

   function automatic logic [Z_W-1:0] sat_z(input logic neg, input logic [NUM_W-1:0] q);
      if (neg || (q == {NUM_W{1'b0}}) || (q > Z_MAX))
         sat_z = Z_FAR;
      else
         sat_z = q[Z_W-1:0];
   endfunction

   state_t state_r, state_nx_s;
   logic signed [COORD_W-1:0] x_r [4];
   logic signed [COORD_W-1:0] y_r [4];
   logic [UV_W-1:0]           u_r [4];
   logic [UV_W-1:0]           v_r [4];
   logic signed [Z_W-1:0]     z_r [4];
   logic signed [COORD_W-1:0] qx_r, qy_r;
   logic signed [AREA_W-1:0]  a_s [6];
   logic signed [AREA_W-1:0]  w_s [3];
   logic [1:0]                vi_s [3];
   logic signed [NUM_W-1:0]   num_s [3];
   logic signed [D_W-1:0]     den_s;
   logic                      neg_s [3];
   logic                      hit_a_s, hit_b_s, hit_s, accept_s;
   logic [D_W-1:0]            d_r;
   logic [D_W-1:0]            rem_r [3];
   logic [NUM_W-1:0]          nq_r [3];
   logic                      neg_r [3];
   logic [D_W-1:0]            rem_nx_s [3];
   logic [NUM_W-1:0]          nq_nx_s [3];
   logic                      tri_r;
   logic [CNT_W-1:0]          cnt_r;
   logic                      in_ready_r, out_valid_r, is_inside_r, tri_id_r;
   logic [UV_W-1:0]           qu_r, qv_r;
   logic [Z_W-1:0]            qz_r;

   assign accept_s  = in_valid && in_ready_r;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign is_inside = is_inside_r;
   assign tri_id    = tri_id_r;
   assign qu        = qu_r;
   assign qv        = qv_r;
   assign qz        = qz_r;

   // Edge-function areas of the query point against both triangles.
   always_comb begin
      a_s[0] = area_f(qx_r, qy_r, x_r[1], y_r[1], x_r[2], y_r[2]);
      a_s[1] = area_f(qx_r, qy_r, x_r[2], y_r[2], x_r[0], y_r[0]);
      a_s[2] = area_f(qx_r, qy_r, x_r[0], y_r[0], x_r[1], y_r[1]);
      a_s[3] = area_f(qx_r, qy_r, x_r[3], y_r[3], x_r[0], y_r[0]);
      a_s[4] = area_f(qx_r, qy_r, x_r[2], y_r[2], x_r[3], y_r[3]);
      a_s[5] = area_f(qx_r, qy_r, x_r[0], y_r[0], x_r[2], y_r[2]);
      hit_a_s = inside_f(a_s[0], a_s[1], a_s[2]);
      hit_b_s = inside_f(a_s[3], a_s[4], a_s[5]);
      hit_s   = hit_a_s || hit_b_s;
   end

   // Pick the weights/vertices of the hit triangle (A wins) and form numerators and divisor.
   always_comb begin
      if (hit_a_s) begin
         w_s[0] = a_s[0]; w_s[1] = a_s[1]; w_s[2] = a_s[2];
         vi_s[0] = 2'd0;  vi_s[1] = 2'd1;  vi_s[2] = 2'd2;
      end else begin
         w_s[0] = a_s[5]; w_s[1] = a_s[3]; w_s[2] = a_s[4];
         vi_s[0] = 2'd3;  vi_s[1] = 2'd2;  vi_s[2] = 2'd0;
      end
      num_s[0] = dot3(ext_uv(u_r[vi_s[0]]), ext_uv(u_r[vi_s[1]]), ext_uv(u_r[vi_s[2]]),
                      ext_a(w_s[0]), ext_a(w_s[1]), ext_a(w_s[2]));
      num_s[1] = dot3(ext_uv(v_r[vi_s[0]]), ext_uv(v_r[vi_s[1]]), ext_uv(v_r[vi_s[2]]),
                      ext_a(w_s[0]), ext_a(w_s[1]), ext_a(w_s[2]));
      num_s[2] = dot3(ext_z(z_r[vi_s[0]]), ext_z(z_r[vi_s[1]]), ext_z(z_r[vi_s[2]]),
                      ext_a(w_s[0]), ext_a(w_s[1]), ext_a(w_s[2]));
      den_s = sum3_d(w_s[0], w_s[1], w_s[2]);
      for (int i = 0; i < 3; i++) begin
         neg_s[i] = num_s[i][NUM_W-1] ^ den_s[D_W-1];
      end
   end

   // Next step of all three dividers; they share the divisor magnitude.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         {rem_nx_s[i], nq_nx_s[i]} = div_step(rem_r[i], nq_r[i], d_r);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE:    if (accept_s) state_nx_s = AREA; else state_nx_s = IDLE;
         AREA:    if (hit_s) state_nx_s = DIVIDE; else state_nx_s = HOLD;
         DIVIDE:  if (cnt_r == CNT_LAST) state_nx_s = HOLD; else state_nx_s = DIVIDE;
         HOLD:    if (out_ready) state_nx_s = IDLE; else state_nx_s = HOLD;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state_r <= IDLE;
      else
         state_r <= state_nx_s;
   end

   // Query capture on the accept cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 4; i++) begin
            x_r[i] <= {COORD_W{1'b0}};
            y_r[i] <= {COORD_W{1'b0}};
            u_r[i] <= {UV_W{1'b0}};
            v_r[i] <= {UV_W{1'b0}};
            z_r[i] <= {Z_W{1'b0}};
         end
         qx_r <= {COORD_W{1'b0}};
         qy_r <= {COORD_W{1'b0}};
      end else if (accept_s) begin
         x_r[0] <= x0; x_r[1] <= x1; x_r[2] <= x2; x_r[3] <= x3;
         y_r[0] <= y0; y_r[1] <= y1; y_r[2] <= y2; y_r[3] <= y3;
         u_r[0] <= u0; u_r[1] <= u1; u_r[2] <= u2; u_r[3] <= u3;
         v_r[0] <= v0; v_r[1] <= v1; v_r[2] <= v2; v_r[3] <= v3;
         z_r[0] <= z0; z_r[1] <= z1; z_r[2] <= z2; z_r[3] <= z3;
         qx_r <= qx;
         qy_r <= qy;
      end
   end

   // Divider load in AREA and one quotient bit per DIVIDE cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         d_r   <= {D_W{1'b0}};
         tri_r <= 1'b0;
         cnt_r <= {CNT_W{1'b0}};
         for (int i = 0; i < 3; i++) begin
            rem_r[i] <= {D_W{1'b0}};
            nq_r[i]  <= {NUM_W{1'b0}};
            neg_r[i] <= 1'b0;
         end
      end else if ((state_r == AREA) && hit_s) begin
         d_r   <= mag_d(den_s);
         tri_r <= !hit_a_s;
         cnt_r <= {CNT_W{1'b0}};
         for (int i = 0; i < 3; i++) begin
            rem_r[i] <= {D_W{1'b0}};
            nq_r[i]  <= mag_n(num_s[i]);
            neg_r[i] <= neg_s[i];
         end
      end else if (state_r == DIVIDE) begin
         cnt_r <= cnt_r + CNT_W'(1);
         for (int i = 0; i < 3; i++) begin
            rem_r[i] <= rem_nx_s[i];
            nq_r[i]  <= nq_nx_s[i];
         end
      end
   end

   // Handshake flags and result registers; results change only on entry to HOLD.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         is_inside_r <= 1'b0;
         tri_id_r    <= 1'b0;
         qu_r        <= {UV_W{1'b0}};
         qv_r        <= {UV_W{1'b0}};
         qz_r        <= Z_FAR;
      end else begin
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == HOLD);
         if ((state_r == AREA) && !hit_s) begin
            is_inside_r <= 1'b0;
            tri_id_r    <= 1'b0;
            qu_r        <= {UV_W{1'b0}};
            qv_r        <= {UV_W{1'b0}};
            qz_r        <= Z_FAR;
         end else if ((state_r == DIVIDE) && (cnt_r == CNT_LAST)) begin
            is_inside_r <= 1'b1;
            tri_id_r    <= tri_r;
            qu_r        <= sat_uv(neg_r[0], nq_nx_s[0]);
            qv_r        <= sat_uv(neg_r[1], nq_nx_s[1]);
            qz_r        <= sat_z(neg_r[2], nq_nx_s[2]);
         end
      end
   end

endmodule

// File: tb/tb_quad_texel_interp.sv
// Self-checking bench for quad_texel_interp: directed table, backpressure/reset
// sequences, and random queries against an integer reference model.
module tb_quad_texel_interp;
   localparam int CW = 10;
   localparam int UW = 4;
   localparam int ZW = 16;
   localparam int NUM_W = ZW + 2*CW + 3 + 2;
   localparam int HIT_LAT = NUM_W + 2;
   localparam int MISS_LAT = 2;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic in_ready, out_valid, is_inside, tri_id;
   logic signed [CW-1:0] x0, x1, x2, x3, y0, y1, y2, y3, qx, qy;
   logic [UW-1:0] u0, u1, u2, u3, v0, v1, v2, v3, qu, qv;
   logic signed [ZW-1:0] z0, z1, z2, z3;
   logic [ZW-1:0] qz;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int x0, x1, x2, x3, y0, y1, y2, y3;
      int u0, u1, u2, u3, v0, v1, v2, v3;
      int z0, z1, z2, z3, qx, qy;
      int e_in, e_tri, e_qu, e_qv, e_qz, e_lat;
   } vec_t;

   quad_texel_interp dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .u0(u0), .u1(u1), .u2(u2), .u3(u3), .v0(v0), .v1(v1), .v2(v2), .v3(v3),
      .z0(z0), .z1(z1), .z2(z2), .z3(z3), .qx(qx), .qy(qy),
      .out_valid(out_valid), .out_ready(out_ready), .is_inside(is_inside),
      .tri_id(tri_id), .qu(qu), .qv(qv), .qz(qz)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic straight from the rules.
   function automatic longint ar(longint px, longint py, longint ax, longint ay, longint bx, longint by);
      return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
   endfunction

   function automatic bit tri_hit(longint a, longint b, longint c);
      return ((a >= 0 && b >= 0 && c >= 0) || (a <= 0 && b <= 0 && c <= 0)) && (a + b + c != 0);
   endfunction

   function automatic int clamp_uv(longint q);
      if (q < 0) return 0;
      if (q > 15) return 15;
      return int'(q);
   endfunction

   function automatic vec_t model(vec_t t);
      vec_t r;
      longint a0, a1, a2, a3, a4, a5, d, nu, nv, nz, q;
      r = t;
      a0 = ar(t.qx, t.qy, t.x1, t.y1, t.x2, t.y2);
      a1 = ar(t.qx, t.qy, t.x2, t.y2, t.x0, t.y0);
      a2 = ar(t.qx, t.qy, t.x0, t.y0, t.x1, t.y1);
      a3 = ar(t.qx, t.qy, t.x3, t.y3, t.x0, t.y0);
      a4 = ar(t.qx, t.qy, t.x2, t.y2, t.x3, t.y3);
      a5 = ar(t.qx, t.qy, t.x0, t.y0, t.x2, t.y2);
      if (tri_hit(a0, a1, a2)) begin
         r.e_tri = 0;
         d  = a0 + a1 + a2;
         nu = t.u0 * a0 + t.u1 * a1 + t.u2 * a2;
         nv = t.v0 * a0 + t.v1 * a1 + t.v2 * a2;
         nz = t.z0 * a0 + t.z1 * a1 + t.z2 * a2;
      end else if (tri_hit(a3, a4, a5)) begin
         r.e_tri = 1;
         d  = a3 + a4 + a5;
         nu = t.u3 * a5 + t.u2 * a3 + t.u0 * a4;
         nv = t.v3 * a5 + t.v2 * a3 + t.v0 * a4;
         nz = t.z3 * a5 + t.z2 * a3 + t.z0 * a4;
      end else begin
         r.e_in = 0; r.e_tri = 0; r.e_qu = 0; r.e_qv = 0; r.e_qz = 65535; r.e_lat = MISS_LAT;
         return r;
      end
      r.e_in  = 1;
      r.e_lat = HIT_LAT;
      r.e_qu  = clamp_uv(nu / d);
      r.e_qv  = clamp_uv(nv / d);
      q = nz / d;
      r.e_qz  = (q <= 0 || q > 32767) ? 65535 : int'(q);
      return r;
   endfunction

   function automatic vec_t square(int qxv, int qyv, int zv);
      vec_t t;
      t.x0 = 0;  t.y0 = 0;  t.x1 = 10; t.y1 = 0;
      t.x2 = 10; t.y2 = 10; t.x3 = 0;  t.y3 = 10;
      t.u0 = 0; t.u1 = 15; t.u2 = 15; t.u3 = 0;
      t.v0 = 0; t.v1 = 0;  t.v2 = 15; t.v3 = 15;
      t.z0 = zv; t.z1 = zv; t.z2 = zv; t.z3 = zv;
      t.qx = qxv; t.qy = qyv;
      t.e_in = 0; t.e_tri = 0; t.e_qu = 0; t.e_qv = 0; t.e_qz = 0; t.e_lat = 0;
      return t;
   endfunction

   function automatic vec_t expect_set(vec_t t, int ein, int etri, int equ, int eqv, int eqz, int elat);
      vec_t r;
      r = t;
      r.e_in = ein; r.e_tri = etri; r.e_qu = equ; r.e_qv = eqv; r.e_qz = eqz; r.e_lat = elat;
      return r;
   endfunction

   task automatic drive(input vec_t t);
      x0 = CW'(t.x0); x1 = CW'(t.x1); x2 = CW'(t.x2); x3 = CW'(t.x3);
      y0 = CW'(t.y0); y1 = CW'(t.y1); y2 = CW'(t.y2); y3 = CW'(t.y3);
      u0 = UW'(t.u0); u1 = UW'(t.u1); u2 = UW'(t.u2); u3 = UW'(t.u3);
      v0 = UW'(t.v0); v1 = UW'(t.v1); v2 = UW'(t.v2); v3 = UW'(t.v3);
      z0 = ZW'(t.z0); z1 = ZW'(t.z1); z2 = ZW'(t.z2); z3 = ZW'(t.z3);
      qx = CW'(t.qx); qy = CW'(t.qy);
   endtask

   task automatic scramble();
      {x0, x1, x2, x3} = {$urandom, $urandom};
      {y0, y1, y2, y3} = {$urandom, $urandom};
      {u0, u1, u2, u3, v0, v1, v2, v3} = $urandom;
      {z0, z1, z2, z3} = {$urandom, $urandom};
      {qx, qy} = $urandom;
   endtask

   // One query; hold_cyc > 0 keeps out_ready low that many cycles in HOLD.
   task automatic apply(input vec_t t, input int hold_cyc, input string tag);
      int k;
      int cyc;
      logic [27:0] snap;
      k = 0;
      while (!in_ready && k < 200) begin
         @(posedge CLK); #1; k++;
      end
      chk({tag, " in_ready"}, in_ready, 1);
      drive(t);
      in_valid = 1'b1;
      out_ready = (hold_cyc == 0);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      scramble();
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(posedge CLK); #1; cyc++;
      end
      chk({tag, " latency"}, cyc, t.e_lat);
      chk({tag, " is_inside"}, is_inside, t.e_in);
      chk({tag, " tri_id"}, tri_id, t.e_tri);
      chk({tag, " qu"}, qu, t.e_qu);
      chk({tag, " qv"}, qv, t.e_qv);
      chk({tag, " qz"}, qz, t.e_qz);
      snap = {is_inside, tri_id, qu, qv, qz, 1'b1, 1'b0};
      for (int i = 0; i < hold_cyc; i++) begin
         in_valid = 1'b1;
         @(posedge CLK); #1;
         chk({tag, " hold stable"}, {is_inside, tri_id, qu, qv, qz, out_valid, in_ready}, snap);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge CLK); #1;
      chk({tag, " post-handshake out_valid"}, out_valid, 0);
      chk({tag, " post-handshake in_ready"}, in_ready, 1);
   endtask

   vec_t tbl [5];
   vec_t t;
   vec_t deg;
   int seen;

   initial begin
      scramble();
      deg = square(3, 0, 100);
      deg.x0 = 0; deg.x1 = 5; deg.x2 = 10; deg.x3 = 15;
      deg.y0 = 0; deg.y1 = 0; deg.y2 = 0;  deg.y3 = 0;
      tbl[0] = expect_set(square(5, 2, 100), 1, 0, 7, 3, 100, HIT_LAT);
      tbl[1] = expect_set(square(2, 5, 100), 1, 1, 3, 7, 100, HIT_LAT);
      tbl[2] = expect_set(square(20, 5, 100), 0, 0, 0, 0, 65535, MISS_LAT);
      tbl[3] = expect_set(square(5, 2, -5), 1, 0, 7, 3, 65535, HIT_LAT);
      tbl[4] = expect_set(deg, 0, 0, 0, 0, 65535, MISS_LAT);

      repeat (3) @(posedge CLK);
      #1;
      chk("reset state", {in_ready, out_valid, is_inside, tri_id, qu, qv, qz},
          {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'hFFFF});
      RESET = 1'b0;
      @(posedge CLK); #1;
      chk("in_ready after reset", in_ready, 1);
      chk("out_valid after reset", out_valid, 0);

      for (int i = 0; i < 5; i++) begin
         apply(tbl[i], 0, $sformatf("dir%0d", i));
      end

      apply(tbl[0], 20, "backpressure");
      @(posedge CLK); #1;
      chk("no queued request", {in_ready, out_valid}, {1'b1, 1'b0});

      drive(tbl[1]);
      in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge CLK);
      #2 RESET = 1'b1;
      #1;
      chk("async reset mid-divide", {in_ready, out_valid, is_inside, tri_id, qu, qv, qz},
          {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'hFFFF});
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(posedge CLK); #1;
      chk("in_ready after mid-divide reset", in_ready, 1);
      seen = 0;
      repeat (60) begin
         @(posedge CLK); #1;
         if (out_valid) seen++;
      end
      chk("aborted result hidden", seen, 0);
      apply(tbl[0], 0, "post-reset");

      for (int n = 0; n < 40; n++) begin
         t = square(0, 0, 0);
         t.x0 = int'($urandom_range(0, 800)) - 400; t.y0 = int'($urandom_range(0, 800)) - 400;
         t.x1 = int'($urandom_range(0, 800)) - 400; t.y1 = int'($urandom_range(0, 800)) - 400;
         t.x2 = int'($urandom_range(0, 800)) - 400; t.y2 = int'($urandom_range(0, 800)) - 400;
         t.x3 = int'($urandom_range(0, 800)) - 400; t.y3 = int'($urandom_range(0, 800)) - 400;
         t.u0 = int'($urandom_range(0, 15)); t.u1 = int'($urandom_range(0, 15));
         t.u2 = int'($urandom_range(0, 15)); t.u3 = int'($urandom_range(0, 15));
         t.v0 = int'($urandom_range(0, 15)); t.v1 = int'($urandom_range(0, 15));
         t.v2 = int'($urandom_range(0, 15)); t.v3 = int'($urandom_range(0, 15));
         t.z0 = int'($urandom_range(0, 65535)) - 32768; t.z1 = int'($urandom_range(0, 65535)) - 32768;
         t.z2 = int'($urandom_range(0, 65535)) - 32768; t.z3 = int'($urandom_range(0, 65535)) - 32768;
         case (n % 3)
            0: begin
               t.qx = (t.x0 + t.x1 + t.x2) / 3 + int'($urandom_range(0, 4)) - 2;
               t.qy = (t.y0 + t.y1 + t.y2) / 3 + int'($urandom_range(0, 4)) - 2;
            end
            1: begin
               t.qx = (t.x0 + t.x2 + t.x3) / 3 + int'($urandom_range(0, 4)) - 2;
               t.qy = (t.y0 + t.y2 + t.y3) / 3 + int'($urandom_range(0, 4)) - 2;
            end
            default: begin
               t.qx = int'($urandom_range(0, 1000)) - 500;
               t.qy = int'($urandom_range(0, 1000)) - 500;
            end
         endcase
         t = model(t);
         apply(t, 0, $sformatf("rand%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/quad_texel_interp.md
QUAD_TEXEL_INTERP -- requirements
Module: quad_texel_interp

Interface
REQ-001 Parameters SHALL be:
- COORD_W, 10, signed screen-coordinate width.
- UV_W, 4, unsigned texel-index width.
- Z_W, 16, signed depth width.
- Z_FAR, all ones of Z_W, depth value for a miss.

REQ-002 Localparams SHALL be AREA_W = 2*COORD_W+3 and NUM_W = Z_W+AREA_W+2.

REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK, input, 1, clock.
- RESET, input, 1, reset, asynchronous, active-high.
- in_valid, input, 1, query request.
- in_ready, output, 1, block can accept a request.
- x0..x3, y0..y3, input, COORD_W signed each, quad vertices.
- u0..u3, v0..v3, input, UV_W unsigned each, vertex texel coordinates.
- z0..z3, input, Z_W signed each, vertex depths.
- qx, qy, input, COORD_W signed each, query point.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- is_inside, output, 1, query hit the quad.
- tri_id, output, 1, triangle hit: 0 = (v0,v1,v2), 1 = (v0,v2,v3).
- qu, qv, output, UV_W each, interpolated texel.
- qz, output, Z_W, interpolated depth.

Function
REQ-004 All vertex, UV, Z and query inputs SHALL be registered on the cycle where in_valid && in_ready (the accept cycle); later input changes SHALL NOT affect the result.

REQ-005 The FSM SHALL have states IDLE, AREA, DIVIDE and HOLD; in_ready SHALL be 1 only in IDLE.

REQ-006 Transitions SHALL be:
- IDLE to AREA on accept.
- AREA to DIVIDE on a hit.
- AREA to HOLD on a miss.
- DIVIDE to HOLD after exactly NUM_W cycles.
- HOLD to IDLE when out_ready = 1.

REQ-007 In AREA the block SHALL compute, at full AREA_W precision with no truncation, where area(P, A, B) = (qx-Ax)(By-Ay) - (qy-Ay)(Bx-Ax):
- a0 = area(q,v1,v2), a1 = area(q,v2,v0), a2 = area(q,v0,v1).
- a3 = area(q,v3,v0), a4 = area(q,v2,v3), a5 = area(q,v0,v2).

REQ-008 Triangle A SHALL hit when a0, a1, a2 are all >= 0 or all <= 0, and a0+a1+a2 != 0; zero area counts as inside, so edges are inclusive.

REQ-009 Triangle B SHALL hit under the same rule on a3, a4, a5 with a3+a4+a5 != 0; triangle A SHALL take priority over triangle B.

REQ-010 A degenerate triangle (area sum = 0) SHALL be treated as a miss for that triangle.

REQ-011 The interpolation numerators SHALL be:
- Triangle A: N_u = u0*a0 + u1*a1 + u2*a2, and likewise for v and z; divisor D = a0+a1+a2.
- Triangle B: N_u = u3*a5 + u2*a3 + u0*a4, and likewise for v and z; divisor D = a3+a4+a5.

REQ-012 DIVIDE SHALL run three iterative restoring dividers in parallel on magnitudes, producing one quotient bit per cycle, sharing |D|.

REQ-013 Quotient sign SHALL be sign(N) XOR sign(D), and quotients SHALL truncate toward zero.

REQ-014 Quotients for qu and qv SHALL be saturated to 0 .. 2^UV_W-1.

REQ-015 If the z quotient is <= 0 or exceeds the maximum positive Z_W value, qz SHALL be Z_FAR; otherwise qz SHALL be the low Z_W bits of the quotient.

REQ-016 On a hit, the outputs SHALL be loaded on entry to HOLD with is_inside = 1 and tri_id set to the triangle hit.

REQ-017 On a miss, the outputs SHALL be loaded on entry to HOLD with is_inside = 0, tri_id = 0, qu = 0, qv = 0 and qz = Z_FAR.

REQ-018 out_valid SHALL be 1 exactly in HOLD, and all result outputs SHALL stay stable while out_valid = 1 and out_ready = 0.

REQ-019 Latency from accept cycle 0 SHALL be: out_valid rises at cycle 2 on a miss and at cycle NUM_W+2 on a hit.

REQ-020 With out_ready held at 1, a new accept SHALL be possible on the cycle after the HOLD handshake; throughput is one query per NUM_W+3 cycles on a hit.

REQ-021 in_valid asserted outside IDLE SHALL be ignored, with no queuing.

Reset
REQ-022 While RESET = 1 the block SHALL hold: state IDLE, in_ready = 0, out_valid = 0, is_inside = 0, tri_id = 0, qu = 0, qv = 0, qz = Z_FAR.

REQ-023 After RESET deasserts, in_ready SHALL be 1 on the first clock edge.

REQ-024 RESET asserted in any state, including mid-DIVIDE, SHALL abort the operation immediately and asynchronously; the aborted result SHALL never be presented.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Hit A: quad (0,0), (10,0), (10,10), (0,10); u = 0, 15, 15, 0; v = 0, 0, 15, 15; z = 100 all; q = (5,2) -> out_valid at cycle 43 (defaults); is_inside = 1, tri_id = 0, qu = 7, qv = 3, qz = 100.
- Hit B: same quad, q = (2,5) -> is_inside = 1, tri_id = 1, qu = 3, qv = 7, qz = 100.
- Miss: same quad, q = (20,5) -> out_valid at cycle 2; is_inside = 0, qu = 0, qv = 0, qz = 16'hFFFF.
- Negative depth: same quad, z = -5 all, q = (5,2) -> is_inside = 1, qz = 16'hFFFF.
- Degenerate: all vertices collinear on y = 0, q = (3,0) -> is_inside = 0.
- Backpressure and reset: hold out_ready = 0 for 20 cycles in HOLD -> outputs stable, in_ready = 0; assert RESET mid-DIVIDE -> reset values at once, and the next query returns a correct result.
